temp_ascii_framer: RTL

Upstream feeder for the UART transmitter. Accepts one signed integer temperature reading and converts it to a fixed 7-byte ASCII frame: sign, hundreds, tens, units, unit char, CR, LF. Presents the frame byte-by-byte on the transmitter's data_byte / active-low tx_start interface and paces on tx_done_tick. Sits between the temperature sensor readout logic and the UART transmitter.

---
 rtl/temp_ascii_framer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/temp_ascii_framer.sv
// rtl/temp_ascii_framer.sv - signed temperature to 7-byte ASCII frame feeder for a UART transmitter
//
// Purpose: captures one signed reading, converts it to decimal digits by repeated
// subtraction, and hands the frame "<sign><H><T><U><UNIT>\r\n" to the transmitter
// one byte at a time, pacing on the transmitter's end-of-byte tick.
//
// Ports:
//   clk             system clock, rising edge
//   reset           asynchronous, active-low
//   temp_valid      one-cycle strobe qualifying temp_c
//   temp_c          signed two's-complement degrees C
//   tx_done_tick    transmitter end-of-byte pulse
//   data_byte       byte presented to the transmitter, held for the whole byte
//   tx_start        active-low, one-cycle transmit request per byte
//   busy            high while a frame is converting or transmitting
//   frame_done_tick one-cycle pulse after the last byte completes
//   drop_tick       one-cycle pulse when a reading arrives while busy
module temp_ascii_framer #(
  parameter bit         SUPPRESS_ZEROS = 1'b1,
  parameter logic [7:0] UNIT_CHAR      = 8'h43
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       temp_valid,
  input  logic [7:0] temp_c,
  input  logic       tx_done_tick,
  output logic [7:0] data_byte,
  output logic       tx_start,
  output logic       busy,
  output logic       frame_done_tick,
  output logic       drop_tick
);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_LOAD, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic        neg_q, neg_d;
  logic [7:0]  mag_q, mag_d;        // after conversion this holds the units digit
  logic [3:0]  hund_q, hund_d;
  logic [3:0]  tens_q, tens_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  data_byte_q, data_byte_d;
  logic        tx_start_q, tx_start_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic        drop_q, drop_d;

  function automatic logic [7:0] frame_byte(
    input logic [2:0] idx,
    input logic       neg,
    input logic [3:0] hund,
    input logic [3:0] tens,
    input logic [3:0] units
  );
    logic [7:0] b;
    case (idx)
      3'd0: b = neg ? 8'h2D : 8'h2B;
      3'd1: b = (SUPPRESS_ZEROS && hund == 4'd0) ? 8'h20 : (8'h30 + {4'h0, hund});
      // A zero tens digit is only blanked when the hundreds digit is blank too.
      3'd2: b = (SUPPRESS_ZEROS && hund == 4'd0 && tens == 4'd0) ? 8'h20 : (8'h30 + {4'h0, tens});
      3'd3: b = 8'h30 + {4'h0, units};
      3'd4: b = UNIT_CHAR;
      3'd5: b = 8'h0D;
      3'd6: b = 8'h0A;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  always_comb begin
    state_d      = state_q;
    neg_d        = neg_q;
    mag_d        = mag_q;
    hund_d       = hund_q;
    tens_d       = tens_q;
    idx_d        = idx_q;
    data_byte_d  = data_byte_q;
    tx_start_d   = 1'b1;
    frame_done_d = 1'b0;
    drop_d       = temp_valid && busy_q;

    case (state_q)
      S_IDLE: begin
        if (temp_valid) begin
          neg_d   = temp_c[7];
          // -128 negates to 8'h80, which read unsigned is the required 128.
          mag_d   = temp_c[7] ? (~temp_c + 8'd1) : temp_c;
          hund_d  = 4'd0;
          tens_d  = 4'd0;
          idx_d   = 3'd0;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        if (mag_q >= 8'd100) begin
          mag_d  = mag_q - 8'd100;
          hund_d = hund_q + 4'd1;
        end else if (mag_q >= 8'd10) begin
          mag_d  = mag_q - 8'd10;
          tens_d = tens_q + 4'd1;
        end else begin
          // Outputs are registered, so the first byte is set up on the way into LOAD.
          state_d     = S_LOAD;
          data_byte_d = frame_byte(3'd0, neg_q, hund_q, tens_q, mag_q[3:0]);
          tx_start_d  = 1'b0;
        end
      end
      S_LOAD: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done_tick) begin
          if (idx_q == 3'd6) begin
            state_d      = S_IDLE;
            idx_d        = 3'd0;
            frame_done_d = 1'b1;
          end else begin
            state_d     = S_LOAD;
            idx_d       = idx_q + 3'd1;
            data_byte_d = frame_byte(idx_q + 3'd1, neg_q, hund_q, tens_q, mag_q[3:0]);
            tx_start_d  = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      neg_q        <= 1'b0;
      mag_q        <= 8'h00;
      hund_q       <= 4'd0;
      tens_q       <= 4'd0;
      idx_q        <= 3'd0;
      data_byte_q  <= 8'h00;
      tx_start_q   <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      neg_q        <= neg_d;
      mag_q        <= mag_d;
      hund_q       <= hund_d;
      tens_q       <= tens_d;
      idx_q        <= idx_d;
      data_byte_q  <= data_byte_d;
      tx_start_q   <= tx_start_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      drop_q       <= drop_d;
    end
  end

  assign data_byte       = data_byte_q;
  assign tx_start        = tx_start_q;
  assign busy            = busy_q;
  assign frame_done_tick = frame_done_q;
  assign drop_tick       = drop_q;

endmodule
